// File: rtl/sreg_pkg.sv
// sreg_pkg: state encoding and counter sizing shared by the PISO transmitter files.
package sreg_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sreg_piso_tx_if.sv
// sreg_piso_tx_if: word-side load handshake plus bit-serial output of the PISO transmitter.
interface sreg_piso_tx_if #(parameter int N = 8);

    logic [N-1:0] load_data;
    logic         load_valid;
    logic         load_ready;
    logic         shift_en;
    logic         sout;
    logic         sout_valid;
    logic         sout_last;
    logic         busy;

    modport master (
        output load_data, load_valid, shift_en,
        input  load_ready, sout, sout_valid, sout_last, busy
    );

    modport slave (
        input  load_data, load_valid, shift_en,
        output load_ready, sout, sout_valid, sout_last, busy
    );

endinterface

// File: rtl/sreg_hold_buf.sv
// sreg_hold_buf: one-entry holding register; load_ready comes straight from the full flag.
module sreg_hold_buf #(
    parameter int N = 8
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic [N-1:0] load_data,
    input  logic         load_valid,
    input  logic         take,
    output logic         load_ready,
    output logic         hold_full,
    output logic [N-1:0] hold
);

    // Accept only while empty, so accept and drain can never coincide.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hold_full <= 1'b0;
            hold      <= '0;
        end else if (load_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold      <= load_data;
        end else if (take) begin
            hold_full <= 1'b0;
        end
    end

    assign load_ready = !hold_full;

endmodule

// File: rtl/sreg_piso_tx.sv
// sreg_piso_tx: parallel-in serial-out transmitter; streams held words back-to-back with no idle bit.
module sreg_piso_tx
    import sreg_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    sreg_piso_tx_if.slave  bus
);

    localparam int             CW       = cnt_w(N);
    localparam logic [CW-1:0] CNT_MAX  = CW'(N - 1);
    localparam logic [CW-1:0] CNT_PENU = CW'(N - 2);

    logic          state;
    logic          hold_full;
    logic          last_q;
    logic          at_end;
    logic          take;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sr;
    logic [N-1:0]  hold;
    logic [N-1:0]  shifted;

    sreg_hold_buf #(.N(N)) u_hold (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .load_data  (bus.load_data),
        .load_valid (bus.load_valid),
        .take       (take),
        .load_ready (bus.load_ready),
        .hold_full  (hold_full),
        .hold       (hold)
    );

    assign at_end  = state == ST_SHIFT && bus.shift_en && cnt == CNT_MAX;
    assign take    = hold_full && (state == ST_IDLE || at_end);
    assign shifted = MSB_FIRST ? {sr[N-2:0], 1'b0} : {1'b0, sr[N-1:1]};

    // Returning to IDLE clears the shifter so sout reads 0 whenever it is not valid.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            sr     <= '0;
            last_q <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (hold_full) begin
                state  <= ST_SHIFT;
                sr     <= hold;
                cnt    <= '0;
                last_q <= 1'b0;
            end
        end else if (bus.shift_en) begin
            if (cnt != CNT_MAX) begin
                sr     <= shifted;
                cnt    <= cnt + 1'b1;
                last_q <= cnt == CNT_PENU;
            end else if (hold_full) begin
                sr     <= hold;
                cnt    <= '0;
                last_q <= 1'b0;
            end else begin
                state  <= ST_IDLE;
                sr     <= '0;
                cnt    <= '0;
                last_q <= 1'b0;
            end
        end
    end

    assign bus.sout       = MSB_FIRST ? sr[N-1] : sr[0];
    assign bus.sout_valid = state == ST_SHIFT;
    assign bus.sout_last  = last_q;
    assign bus.busy       = state == ST_SHIFT || hold_full;

endmodule
